// File: rtl/redmule_z_collector.sv
// redmule_z_collector: gathers Z columns from the row array into ping-pong tiles
// and drains each tile row by row over a valid/ready stream.
module redmule_z_collector #(
   // FpFormat follows fpnew_pkg::fp_format_e ordering (FP32, FP64, FP16, FP8, FP16ALT); default FP16
   parameter int unsigned FpFormat = 2,
   parameter int unsigned Width    = 4,
   parameter int unsigned Depth    = 4,
   localparam int unsigned BITW = (FpFormat == 0) ? 32 : (FpFormat == 1) ? 64 : (FpFormat == 3) ? 8 : 16,
   localparam int unsigned RowW = (Width > 1) ? $clog2(Width) : 1,
   localparam int unsigned ColW = ($clog2(Depth + 1) > 1) ? $clog2(Depth + 1) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clear_i,
   input  logic                        in_valid_i,
   input  logic [Width-1:0][BITW-1:0]  in_data_i,
   input  logic                        in_last_i,
   output logic                        in_ready_o,
   output logic                        out_valid_o,
   output logic [Depth-1:0][BITW-1:0]  out_data_o,
   output logic [RowW-1:0]             out_row_o,
   output logic                        out_last_o,
   input  logic                        out_ready_i,
   output logic                        busy_o
);
   logic [1:0][Width-1:0][Depth-1:0][BITW-1:0] tile_q;
   logic [1:0]      full_q;
   logic            wr_q, rd_q;
   logic [ColW-1:0] col_q;
   logic [RowW-1:0] row_q;
   logic            cap, beat, close, drained;
   assign in_ready_o  = ~full_q[wr_q];
   assign out_valid_o = full_q[rd_q];
   assign out_data_o  = tile_q[rd_q][row_q];
   assign out_row_o   = row_q;
   assign drained     = row_q == RowW'(Width - 1);
   assign out_last_o  = drained;
   assign cap         = in_valid_i & in_ready_o;
   assign beat        = out_valid_o & out_ready_i;
   assign close       = in_last_i | (col_q == ColW'(Depth - 1));
   assign busy_o      = |full_q | (col_q != '0);
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tile_q <= '0;
         full_q <= '0;
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         col_q  <= '0;
         row_q  <= '0;
      end else if (clear_i) begin
         full_q <= '0;
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         col_q  <= '0;
         row_q  <= '0;
      end else begin
         if (cap) begin
            // an early close zero-pads the unused trailing columns
            for (int r = 0; r < int'(Width); r++)
               for (int c = 0; c < int'(Depth); c++)
                  if (c == int'(col_q)) tile_q[wr_q][r][c] <= in_data_i[r];
                  else if (in_last_i && c > int'(col_q)) tile_q[wr_q][r][c] <= '0;
            if (close) begin
               full_q[wr_q] <= 1'b1;
               wr_q         <= ~wr_q;
               col_q        <= '0;
            end else col_q <= col_q + 1'b1;
         end
         if (beat) begin
            if (drained) begin
               full_q[rd_q] <= 1'b0;
               rd_q         <= ~rd_q;
               row_q        <= '0;
            end else row_q <= row_q + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_redmule_z_collector.sv
// tb_redmule_z_collector: randomized scoreboard bench with a tile-level reference model.
module tb_redmule_z_collector;
   localparam int W = 2, D = 3, B = 16;
   typedef logic [D-1:0][B-1:0] row_t;
   typedef struct {row_t data; int row;} exp_t;

   logic clk = 0, rst_i = 1, clear_i = 0, in_valid = 0, in_last = 0, out_ready = 0;
   logic [W-1:0][B-1:0] in_data = '0;
   logic in_ready, out_valid, out_last, busy;
   row_t out_data;
   logic [0:0] out_row;

   exp_t q[$];
   logic [B-1:0] cur [W][D];
   int col_m = 0, outst = 0, tests = 0, fails = 0;

   always #5 clk = ~clk;

   redmule_z_collector #(.FpFormat(2), .Width(W), .Depth(D)) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last), .in_ready_o(in_ready),
      .out_valid_o(out_valid), .out_data_o(out_data), .out_row_o(out_row), .out_last_o(out_last),
      .out_ready_i(out_ready), .busy_o(busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      outst = 0;
      col_m = 0;
   endtask

   // Monitor: tiles outstanding decide ready/valid; the queue front is the row owed on the stream.
   always @(negedge clk) begin
      if (rst_i) begin
         model_reset();
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_data", out_data, 0);
         chk("rst_out_row", out_row, 0);
         chk("rst_out_last", out_last, 0);
         chk("rst_busy", busy, 0);
      end else begin
         automatic bit cap = in_valid && outst < 2;
         automatic bit bt = outst > 0 && out_ready;
         chk("in_ready", in_ready, outst < 2);
         chk("out_valid", out_valid, outst > 0);
         chk("busy", busy, outst > 0 || col_m != 0);
         if (out_valid && q.size() > 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_row", out_row, q[0].row);
            chk("out_last", out_last, q[0].row == W - 1);
         end
         if (clear_i) model_reset();
         else begin
            if (bt && q.size() > 0) begin
               if (q[0].row == W - 1) outst--;
               void'(q.pop_front());
            end
            if (cap) begin
               for (int r = 0; r < W; r++) cur[r][col_m] = in_data[r];
               if (in_last || col_m == D - 1) begin
                  for (int r = 0; r < W; r++) begin
                     exp_t e;
                     e.row = r;
                     for (int c = 0; c < D; c++) e.data[c] = (c <= col_m) ? cur[r][c] : '0;
                     q.push_back(e);
                  end
                  outst++;
                  col_m = 0;
               end else col_m++;
            end
         end
      end
   end

   task automatic send(input logic [W-1:0][B-1:0] d, input logic l, output int stalls);
      bit ok;
      in_data = d;
      in_last = l;
      in_valid = 1;
      stalls = 0;
      forever begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) break;
         stalls++;
         if (stalls > 200) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 200 cycles");
            break;
         end
      end
      in_valid = 0;
      in_last = 0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      chk("idle_reached", out_valid, 0);
   endtask

   initial begin
      int s, tot;
      repeat (2) @(posedge clk);
      #1 rst_i = 0;
      out_ready = 1;
      // basic tile
      send({16'h4000, 16'h3C00}, 0, s);
      send({16'h4400, 16'h4200}, 0, s);
      send({16'h4600, 16'h4500}, 0, s);
      @(negedge clk);
      chk("basic_row0", out_data, {16'h4500, 16'h4200, 16'h3C00});
      @(posedge clk);
      #1;
      wait_idle();
      // early close then a fresh tile
      send(32'h11112222, 0, s);
      send(32'h33334444, 1, s);
      send(32'h55556666, 0, s);
      send(32'h77778888, 0, s);
      send(32'h9999aaaa, 0, s);
      wait_idle();
      // back-pressure: 6 captures fill both buffers, the 7th is held
      out_ready = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) send($urandom, 0, s);
            send($urandom, 0, s);
            chk("bp_held", s > 0, 1);
         end
         begin
            repeat (12) @(posedge clk);
            #1 out_ready = 1;
         end
      join
      wait_idle();
      // overlap: continuous input never stalls
      tot = 0;
      for (int i = 0; i < 4 * D; i++) begin
         send($urandom, 0, s);
         tot += s;
      end
      chk("overlap_stalls", tot, 0);
      wait_idle();
      // clear with one tile full and one column pending
      out_ready = 0;
      for (int i = 0; i < 4; i++) send($urandom, 0, s);
      clear_i = 1;
      @(posedge clk);
      #1 clear_i = 0;
      @(negedge clk);
      chk("clear_valid", out_valid, 0);
      chk("clear_ready", in_ready, 1);
      // same again with asynchronous reset
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) send($urandom, 0, s);
      #1 rst_i = 1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_busy", busy, 0);
      @(posedge clk);
      #1 rst_i = 0;
      // random traffic with random back-pressure
      fork
         for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            send($urandom, ($urandom % 5) == 0, s);
         end
         repeat (600) begin
            @(posedge clk);
            #1 out_ready = $urandom % 2;
         end
      join
      out_ready = 1;
      repeat (30) @(posedge clk);
      #1;
      chk("final_drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
